// File: rtl/entry_session_arbiter_pkg.sv
// Shared types and constants for the entry session arbiter: FSM states,
// interface indices and code widths.
package entry_session_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic IE01 = 1'b0;
  localparam logic IE02 = 1'b1;

  localparam int USER_W = 3;
  localparam int FEAT_W = 3;
endpackage

// File: rtl/entry_session_arbiter_arb_priority_pick.sv
// Combinational winner pick between IE01 and IE02: higher user code wins,
// ties go to rr, and an excluded interface is never eligible.
module arb_priority_pick
  import entry_session_arbiter_pkg::*;
(
  input  logic              req0,
  input  logic              req1,
  input  logic [USER_W-1:0] user0,
  input  logic [USER_W-1:0] user1,
  input  logic              rr,
  input  logic              excl,
  input  logic              excl_idx,
  output logic              winner,
  output logic              found
);
  logic elig0;
  logic elig1;

  always_comb begin
    elig0  = req0 && !(excl && (excl_idx == IE01));
    elig1  = req1 && !(excl && (excl_idx == IE02));
    found  = elig0 || elig1;
    winner = IE01;
    if (elig0 && elig1) begin
      if (user1 > user0)      winner = IE02;
      else if (user0 > user1) winner = IE01;
      else                    winner = rr;
    end else if (elig1) begin
      winner = IE02;
    end
  end
endmodule

// File: rtl/entry_session_arbiter.sv
// Registered session arbiter sharing the output resources between IE01 and
// IE02, with minimum/maximum hold and a one-cycle blanking gap on handover.
module entry_session_arbiter
  import entry_session_arbiter_pkg::*;
#(
  parameter int HOLD_MIN = 4,
  parameter int HOLD_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [USER_W-1:0] user0,
  input  logic [USER_W-1:0] user1,
  input  logic [FEAT_W-1:0] feat0,
  input  logic [FEAT_W-1:0] feat1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              owner,
  output logic              grant_valid,
  output logic [USER_W-1:0] grant_user,
  output logic [FEAT_W-1:0] grant_feat
);
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(HOLD_MIN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              rr;
  logic              excl_q;
  logic              pick_win;
  logic              pick_found;
  logic              own_req;
  logic              oth_req;
  logic [USER_W-1:0] own_user;
  logic [USER_W-1:0] oth_user;
  logic [FEAT_W-1:0] own_feat;
  logic              preempt;
  logic              sess_end;

  // A preempted owner is barred only for the GAP that follows its own session.
  arb_priority_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .user0    (user0),
    .user1    (user1),
    .rr       (rr),
    .excl     ((state == GAP) && excl_q),
    .excl_idx (owner),
    .winner   (pick_win),
    .found    (pick_found)
  );

  always_comb begin
    own_req  = owner ? req1  : req0;
    oth_req  = owner ? req0  : req1;
    own_user = owner ? user1 : user0;
    oth_user = owner ? user0 : user1;
    own_feat = owner ? feat1 : feat0;
    preempt  = oth_req && (((cnt >= CNT_MIN) && (oth_user > grant_user)) || (cnt == CNT_MAX));
    sess_end = !own_req || (own_user != grant_user) || (own_feat != grant_feat) || preempt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      grant_valid <= 1'b0;
      owner       <= IE01;
      grant_user  <= '0;
      grant_feat  <= '0;
      cnt         <= '0;
      rr          <= IE01;
      excl_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          excl_q <= 1'b0;
          if (pick_found) begin
            state       <= pick_win ? GRANT1 : GRANT0;
            gnt0        <= !pick_win;
            gnt1        <= pick_win;
            grant_valid <= 1'b1;
            owner       <= pick_win;
            grant_user  <= pick_win ? user1 : user0;
            grant_feat  <= pick_win ? feat1 : feat0;
            cnt         <= '0;
            rr          <= !pick_win;
          end else begin
            state <= IDLE;
          end
        end
        GRANT0, GRANT1: begin
          if (sess_end) begin
            state       <= GAP;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            grant_valid <= 1'b0;
            excl_q      <= preempt;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_entry_session_arbiter.sv
// Self-checking bench for entry_session_arbiter: directed scenarios plus a
// randomized run against a session-level reference model.
module tb_entry_session_arbiter;
  localparam int HOLD_MIN = 4;
  localparam int HOLD_MAX = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [2:0] user0, user1, feat0, feat1;
  logic       gnt0, gnt1, owner, grant_valid;
  logic [2:0] grant_user, grant_feat;

  int total = 0;
  int bad   = 0;

  // Reference model: session view of the arbiter
  bit m_sess, m_gap;
  int m_owner, m_user, m_feat, m_rr, m_age, m_block;

  always #5 clk = ~clk;

  entry_session_arbiter #(.HOLD_MIN(HOLD_MIN), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .user0(user0), .user1(user1), .feat0(feat0), .feat1(feat1),
    .gnt0(gnt0), .gnt1(gnt1), .owner(owner), .grant_valid(grant_valid),
    .grant_user(grant_user), .grant_feat(grant_feat)
  );

  task automatic model_step();
    int rq[2], us[2], ft[2];
    int oth, w;
    bit pre, fin, e0, e1;
    rq[0] = int'(req0);  rq[1] = int'(req1);
    us[0] = int'(user0); us[1] = int'(user1);
    ft[0] = int'(feat0); ft[1] = int'(feat1);
    if (rst) begin
      m_sess = 0; m_gap = 0; m_owner = 0; m_user = 0; m_feat = 0;
      m_rr = 0; m_age = 0; m_block = -1;
    end else if (m_sess) begin
      oth = 1 - m_owner;
      pre = (rq[oth] == 1) && (((m_age >= HOLD_MIN) && (us[oth] > m_user)) || (m_age >= HOLD_MAX));
      fin = (rq[m_owner] == 0) || (us[m_owner] != m_user) || (ft[m_owner] != m_feat) || pre;
      if (fin) begin
        m_sess = 0; m_gap = 1; m_block = pre ? m_owner : -1;
      end else if (m_age < HOLD_MAX) begin
        m_age++;
      end
    end else begin
      e0 = (rq[0] == 1) && !(m_gap && m_block == 0);
      e1 = (rq[1] == 1) && !(m_gap && m_block == 1);
      m_gap = 0; m_block = -1;
      if (e0 || e1) begin
        if (e0 && e1) w = (us[1] > us[0]) ? 1 : (us[0] > us[1]) ? 0 : m_rr;
        else          w = e1 ? 1 : 0;
        m_sess = 1; m_owner = w; m_user = us[w]; m_feat = ft[w];
        m_age = 0; m_rr = 1 - w;
      end
    end
  endtask

  function automatic logic [9:0] mexp();
    logic g0, g1;
    g0 = m_sess && (m_owner == 0);
    g1 = m_sess && (m_owner == 1);
    return {g0, g1, 1'(m_owner), g0 | g1, 3'(m_user), 3'(m_feat)};
  endfunction

  function automatic logic [9:0] dout();
    return {gnt0, gnt1, owner, grant_valid, grant_user, grant_feat};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic go_idle();
    req0 = 0; req1 = 0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1; req0 = 0; req1 = 0; user0 = 0; user1 = 0; feat0 = 0; feat1 = 0;
    tick(); tick();
    total++;
    if (dout() !== 10'h000) begin bad++; $display("FAIL reset_state: got=%h want=%h", dout(), 10'h000); end
    rst = 0; req0 = 1; user0 = 3; feat0 = 2;
    tick();
    total++;
    if (dout() !== {4'b1001, 3'd3, 3'd2}) begin bad++; $display("FAIL first_grant: got=%h want=%h", dout(), {4'b1001, 3'd3, 3'd2}); end
    total++;
    if (dout() !== mexp()) begin bad++; $display("FAIL first_grant_model: got=%h want=%h", dout(), mexp()); end
  endtask

  task automatic test_priority();
    go_idle();
    req0 = 1; req1 = 1; user0 = 2; user1 = 5;
    tick();
    total++;
    if ({gnt0, gnt1, grant_user} !== {2'b01, 3'd5}) begin bad++; $display("FAIL higher_user: got=%b want=%b", {gnt0, gnt1, grant_user}, {2'b01, 3'd5}); end
    go_idle();
    req0 = 1; req1 = 1; user0 = 4; user1 = 4;
    tick();
    total++;
    if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL tie_first: got=%b want=%b", {gnt0, gnt1}, 2'b10); end
    go_idle();
    req0 = 1; req1 = 1;
    tick();
    total++;
    if ({gnt0, gnt1} !== 2'b01) begin bad++; $display("FAIL tie_second: got=%b want=%b", {gnt0, gnt1}, 2'b01); end
    total++;
    if (dout() !== mexp()) begin bad++; $display("FAIL tie_model: got=%h want=%h", dout(), mexp()); end
  endtask

  task automatic test_min_hold();
    go_idle();
    req0 = 1; user0 = 1; feat0 = 0;
    tick();
    tick();
    req1 = 1; user1 = 6;
    for (int k = 2; k <= HOLD_MIN; k++) begin
      tick();
      total++;
      if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL min_hold_k%0d: got=%b want=%b", k, {gnt0, gnt1}, 2'b10); end
    end
    tick();
    total++;
    if ({gnt0, gnt1, grant_valid, grant_user} !== {3'b000, 3'd1}) begin bad++; $display("FAIL min_hold_gap: got=%b want=%b", {gnt0, gnt1, grant_valid, grant_user}, {3'b000, 3'd1}); end
    tick();
    total++;
    if ({gnt0, gnt1, owner, grant_user} !== {3'b011, 3'd6}) begin bad++; $display("FAIL min_hold_take: got=%b want=%b", {gnt0, gnt1, owner, grant_user}, {3'b011, 3'd6}); end
  endtask

  task automatic test_max_hold();
    int n;
    go_idle();
    req0 = 1; user0 = 3; feat0 = 1;
    tick();
    req1 = 1; user1 = 3; feat1 = 5;
    n = 0;
    while (gnt0 && n < 200) begin
      tick();
      n++;
      total++;
      if (dout() !== mexp()) begin bad++; $display("FAIL max_hold_c%0d: got=%h want=%h", n, dout(), mexp()); end
    end
    total++;
    if (n !== HOLD_MAX + 1) begin bad++; $display("FAIL max_hold_len: got=%0d want=%0d", n, HOLD_MAX + 1); end
    tick();
    total++;
    if ({gnt1, grant_feat} !== {1'b1, 3'd5}) begin bad++; $display("FAIL max_hold_take: got=%b want=%b", {gnt1, grant_feat}, {1'b1, 3'd5}); end
  endtask

  task automatic test_feat_change();
    go_idle();
    req1 = 1; user1 = 2; feat1 = 1;
    tick(); tick(); tick();
    feat1 = 4;
    tick();
    total++;
    if ({gnt1, grant_valid, grant_feat} !== {2'b00, 3'd1}) begin bad++; $display("FAIL feat_gap: got=%b want=%b", {gnt1, grant_valid, grant_feat}, {2'b00, 3'd1}); end
    tick();
    total++;
    if ({gnt1, grant_valid, grant_feat} !== {2'b11, 3'd4}) begin bad++; $display("FAIL feat_regrant: got=%b want=%b", {gnt1, grant_valid, grant_feat}, {2'b11, 3'd4}); end
  endtask

  task automatic test_reset_mid();
    tick();
    rst = 1;
    tick();
    total++;
    if (dout() !== 10'h000) begin bad++; $display("FAIL mid_reset: got=%h want=%h", dout(), 10'h000); end
    rst = 0; req0 = 1; req1 = 1; user0 = 5; user1 = 5;
    tick();
    total++;
    if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL post_reset_tie: got=%b want=%b", {gnt0, gnt1}, 2'b10); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 11))
        0: req0  = ~req0;
        1: req1  = ~req1;
        2: user0 = 3'($urandom_range(0, 7));
        3: user1 = 3'($urandom_range(0, 7));
        4: feat0 = 3'($urandom_range(0, 7));
        5: feat1 = 3'($urandom_range(0, 7));
        default: ;
      endcase
      tick();
      total++;
      if (dout() !== mexp()) begin bad++; $display("FAIL random_c%0d: got=%h want=%h", c, dout(), mexp()); end
      total++;
      if ((gnt0 & gnt1) !== 1'b0) begin bad++; $display("FAIL random_excl_c%0d: got=%b want=0", c, gnt0 & gnt1); end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_min_hold();
    test_max_hold();
    test_feat_change();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/entry_session_arbiter.md
# entry_session_arbiter

Sequential arbiter that shares the single output resource set (seven-segment display, LED matrix, sequential LEDs) between entry interfaces IE01 and IE02. It sits between the per-interface permission/user/feature logic and the output decoders. It replaces the purely combinational priority pick with registered sessions that have a minimum hold, a maximum hold and a one-cycle blanking gap.

## Interface
Parameters:
- HOLD_MIN, 4: cycles a session is protected from priority preemption; range 1 to HOLD_MAX.
- HOLD_MAX, 64: cycles after which a waiting opposite requester takes over regardless of priority.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0  in  1  IE01 request; this is the IE01 permission result.
- req1  in  1  IE02 request; this is the IE02 permission result.
- user0  in  3  IE01 user code.
- user1  in  3  IE02 user code.
- feat0  in  3  IE01 feature code.
- feat1  in  3  IE02 feature code.
- gnt0  out  1  IE01 owns the outputs.
- gnt1  out  1  IE02 owns the outputs.
- owner  out  1  last/current owner: 0 = IE01, 1 = IE02.
- grant_valid  out  1  equals gnt0 | gnt1.
- grant_user  out  3  user code latched at grant.
- grant_feat  out  3  feature code latched at grant.

## Operation
- States: IDLE, GRANT0, GRANT1, GAP. All outputs are registered.
- Reset values:
  - state IDLE;
  - gnt0 = gnt1 = grant_valid = 0;
  - grant_user = grant_feat = 0;
  - owner = 0;
  - round-robin pointer rr = 0 (next tie goes to IE01);
  - hold counter = 0.
- Winner selection (IDLE and GAP):
  - Only one req high: that interface wins.
  - Both high: the higher unsigned user code wins.
  - Both high with equal user codes: the interface indicated by rr wins.
  - On every grant, rr points to the non-granted interface.
- On grant:
  - Enter GRANTx and set gntx.
  - Latch userx/featx into grant_user/grant_feat.
  - Set owner = x and clear the counter.
- Counter behaviour:
  - The counter increments every cycle in GRANTx and saturates at HOLD_MAX.
  - Width is clog2(HOLD_MAX+1); the counter never wraps.
- Session end in GRANTx. Any of the following sends the arbiter to GAP:
  - (a) reqx drops;
  - (b) userx or featx differs from the latched value;
  - (c) counter >= HOLD_MIN, the other req is high, and its user code is strictly higher than grant_user;
  - (d) counter == HOLD_MAX and the other req is high.
- Without a competing request, a session lasts indefinitely at a saturated counter.
- GAP behaviour:
  - Exactly one cycle with gnt0 = gnt1 = grant_valid = 0.
  - grant_user, grant_feat and owner keep their last values.
  - Winner selection runs in GAP; if no req is high, the next state is IDLE.
- After end reasons (c) or (d), the ending owner may not win the GAP arbitration; the other interface is granted.
- Simultaneous events:
  - If reqx drops while a condition (c) or (d) holds, the result is the same: GAP, then the other interface.
- Reset mid-session forces the reset values on the next edge, with no GAP.

## Timing
- A req sampled high in IDLE at edge N gives gnt high after edge N; the output latency is 1 cycle.
- A session end detected at edge N drops gnt after edge N (GAP). The new gnt rises after edge N+1.
- gnt0 and gnt1 are never high in the same cycle. Every ownership change passes through at least one cycle with grant_valid = 0.
- Inputs are sampled only at rising edges and are assumed synchronous to clk; debounce and synchronisation happen upstream.

## Structure
- Shared package holds:
  - state encoding constants (IDLE, GRANT0, GRANT1, GAP);
  - interface index constants (IE01 = 0, IE02 = 1);
  - USER_W = 3 and FEAT_W = 3.
- One combinational sub-module, arb_priority_pick, takes two req/user pairs plus rr and an exclude flag, and returns a winner index and a found flag. It is used in IDLE and in GAP.
- The state register, counter, latches and outputs live in the top module.

## Test plan
- Reset, then req0 = 1 with user0 = 3 and feat0 = 2 → gnt0 = 1 one cycle later, with grant_user = 3, grant_feat = 2 and owner = 0.
- In IDLE, req0 and req1 rise together with user0 = 2 and user1 = 5 → gnt1 next cycle. Repeat with equal users → IE01 wins the first tie and IE02 the second.
- IE01 granted with user 1; req1 rises with user 6 at counter = 1 → gnt0 holds until counter = HOLD_MIN (4). Then one GAP cycle, then gnt1 = 1.
- IE01 granted; req1 has an equal or lower user and is held high → handover at counter = 64 via GAP. Check that gnt1 rises exactly 2 cycles after the counter reaches 64.
- While IE02 is granted, feat1 changes from 1 to 4 → GAP. Then IE02 is regranted with grant_feat = 4 if still requesting and unopposed.
- rst asserted mid-GRANT1 → all outputs return to reset values at the next edge. The first post-reset tie goes to IE01.
